// File: rtl/sam_pwm_tx_if.sv
// Bundled request/line signals between a frame source and the SAM pulse-width transmitter.
// The source drives start/data/len; the transmitter drives the serial line and status flags.
interface sam_pwm_tx_if #(
    parameter int MSG_W = 8,
    parameter int LEN_W = 4
);
    logic             start;
    logic [MSG_W-1:0] data;
    logic [LEN_W-1:0] len;
    logic             str;
    logic             busy;
    logic             done;

    modport master (
        output start, data, len,
        input  str, busy, done
    );

    modport slave (
        input  start, data, len,
        output str, busy, done
    );
endinterface

// File: rtl/sam_pwm_tx.sv
// SAM pulse-width transmitter: serialises data[len-1:0] MSB-first as high/low symbol pairs
// on str, then a terminator pulse and a low gap, then pulses done for one cycle.
// Optional feature macro: SAM_TX_PARITY_EN adds an even-parity symbol after data[0].
module sam_pwm_tx #(
    parameter int MSG_W   = 8,
    parameter int LEN_W   = 4,
    parameter int T_HI1   = 12,
    parameter int T_LO1   = 4,
    parameter int T_HI0   = 4,
    parameter int T_LO0   = 12,
    parameter int TERM_HI = 2,
    parameter int GAP     = 4
) (
    input  logic         clk,
    input  logic         reset,
    sam_pwm_tx_if.slave  bus
);

    // Legal timing set; anything else is rejected when the design is elaborated.
    localparam bit CFG_OK =
        (T_HI1 >= 1) && (T_LO1 >= 1) && (T_HI0 >= 1) && (T_LO0 >= 1) &&
        (TERM_HI >= 1) && (GAP >= 1) &&
        (T_HI1 + T_LO1 >= 10) && (T_HI1 + T_LO1 <= 60) &&
        (T_HI0 + T_LO0 >= 10) && (T_HI0 + T_LO0 <= 60) &&
        (T_HI1 >= T_LO1) && (T_HI0 < T_LO0) &&
        (MSG_W < (1 << LEN_W));

    if (!CFG_OK) begin : g_cfg_error
        $error("sam_pwm_tx: illegal timing/width configuration");
    end

    // Run lengths are loaded as T-1; the state moves on when the counter reads 0.
    localparam logic [5:0] HI1_M1  = 6'(T_HI1 - 1);
    localparam logic [5:0] LO1_M1  = 6'(T_LO1 - 1);
    localparam logic [5:0] HI0_M1  = 6'(T_HI0 - 1);
    localparam logic [5:0] LO0_M1  = 6'(T_LO0 - 1);
    localparam logic [5:0] TERM_M1 = 6'(TERM_HI - 1);
    localparam logic [5:0] GAP_M1  = 6'(GAP - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MSG_W);

    typedef enum logic [2:0] {IDLE, HIGH, LOW, TERM, GAP_ST} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [MSG_W-1:0] data_q, data_d;
    logic             str_q, str_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] len_c;
    logic [MSG_W-1:0] first_sh, cur_sh, next_sh;
    logic             cur_bit;

    function automatic logic [5:0] hi_m1(input logic b);
        return b ? HI1_M1 : HI0_M1;
    endfunction

    function automatic logic [5:0] lo_m1(input logic b);
        return b ? LO1_M1 : LO0_M1;
    endfunction

    // Oversized requests are clamped to the widest frame the word can hold.
    assign len_c = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;

    // Bit selection by shifting avoids index-width mismatches against the data word.
    assign first_sh = bus.data >> (len_c - 1'b1);
    assign cur_sh   = data_q >> idx_q;
    assign next_sh  = data_q >> (idx_q - 1'b1);

`ifdef SAM_TX_PARITY_EN
    logic par_q, par_d;
    logic par_ph_q, par_ph_d;
    logic in_par;

    // Even parity over exactly the bits that will be sent in this frame.
    always_comb begin
        in_par = 1'b0;
        for (int i = 0; i < MSG_W; i++) begin
            if (i < int'(len_c)) in_par = in_par ^ bus.data[i];
        end
    end

    assign cur_bit = par_ph_q ? par_q : cur_sh[0];
`else
    assign cur_bit = cur_sh[0];
`endif

    // Next-state, next-counter and next-output decode for the symbol sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        str_d   = str_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SAM_TX_PARITY_EN
        par_d    = par_q;
        par_ph_d = par_ph_q;
`endif
        unique case (state_q)
            IDLE: begin
                str_d  = 1'b0;
                busy_d = 1'b0;
                if (bus.start) begin
                    if (len_c != '0) begin
                        data_d  = bus.data;
                        idx_d   = len_c - 1'b1;
                        cnt_d   = hi_m1(first_sh[0]);
                        state_d = HIGH;
                        str_d   = 1'b1;
                        busy_d  = 1'b1;
`ifdef SAM_TX_PARITY_EN
                        par_d    = in_par;
                        par_ph_d = 1'b0;
`endif
                    end else begin
                        // Empty frame: nothing on the line, just acknowledge.
                        done_d = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    str_d   = 1'b0;
                    cnt_d   = lo_m1(cur_bit);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    if (idx_q != '0) begin
                        idx_d   = idx_q - 1'b1;
                        state_d = HIGH;
                        str_d   = 1'b1;
                        cnt_d   = hi_m1(next_sh[0]);
`ifdef SAM_TX_PARITY_EN
                    end else if (!par_ph_q) begin
                        par_ph_d = 1'b1;
                        state_d  = HIGH;
                        str_d    = 1'b1;
                        cnt_d    = hi_m1(par_q);
`endif
                    end else begin
                        state_d = TERM;
                        str_d   = 1'b1;
                        cnt_d   = TERM_M1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TERM: begin
                if (cnt_q == '0) begin
                    state_d = GAP_ST;
                    str_d   = 1'b0;
                    cnt_d   = GAP_M1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP_ST: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                str_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters, captured message and registered line outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the captured message word is reset too; it is a small register, not a RAM.
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            str_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SAM_TX_PARITY_EN
            par_q    <= 1'b0;
            par_ph_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            str_q   <= str_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SAM_TX_PARITY_EN
            par_q    <= par_d;
            par_ph_q <= par_ph_d;
`endif
        end
    end

    assign bus.str  = str_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
